data_cache_line_writeback: RTL and testbench

- Eviction/writeback engine for the data cache; the read-side counterpart of the byte-enabled word storage that the CPU writes.
- On request, reads one dirty line word by word from the data array's synchronous read port and streams it to main memory over a valid/ready beat interface.
- Sits between the cache controller (request/done), the data array read port, and the memory write channel.

---
 rtl/dcache_pkg.sv | 18 +
 rtl/wb_beat_buffer.sv | 55 +++++
 rtl/data_cache_line_writeback.sv | 154 +++++++++++++++
 tb/tb_data_cache_line_writeback.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache writeback path: FSM state codes,
// word geometry constants and the line-size helper.
package dcache_pkg;

    // Writeback FSM state codes
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int unsigned WORD_BYTES = 32'd4;
    localparam logic [3:0]  STRB_FULL  = 4'hF;

    // Number of 32-bit words held by one cache line
    function automatic int unsigned line_words(input int unsigned word_addr_width);
        return 32'd1 << word_addr_width;
    endfunction

endpackage

// File: rtl/wb_beat_buffer.sv
// Two-entry FIFO holding {word index, word data} between the array read port
// and the memory beat interface. A push and a pop may happen on the same edge.
module wb_beat_buffer #(
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push,
    input  logic [IDX_W-1:0]  push_idx,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [IDX_W-1:0]  head_idx,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occupancy,
    output logic              empty
);

    logic [1:0][IDX_W-1:0]  idx_r;
    logic [1:0][DATA_W-1:0] data_r;
    logic                   wr_ptr_r;
    logic                   rd_ptr_r;
    logic [1:0]             count_r;

    // Storage, pointers and occupancy; push and pop are independent
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_r    <= '0;
            data_r   <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                idx_r[wr_ptr_r]  <= push_idx;
                data_r[wr_ptr_r] <= push_data;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_idx  = idx_r[rd_ptr_r];
    assign head_data = data_r[rd_ptr_r];
    assign occupancy = count_r;
    assign empty     = (count_r == 2'd0);

endmodule

// File: rtl/data_cache_line_writeback.sv
// Data-cache line writeback engine: reads one line word by word from the
// data array's synchronous read port and streams it to memory as valid/ready
// beats. Optional macro DCACHE_WB_STALL_CNT_EN adds wb_stall_cnt_o, a
// saturating count of cycles where a beat was offered but not accepted.
module data_cache_line_writeback
    import dcache_pkg::*;
#(
    parameter int unsigned WORD_ADDR_WIDTH = 3,
    parameter int unsigned MEM_ADDR_WIDTH  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wb_req_valid_i,
    output logic                       wb_req_ready_o,
    input  logic [MEM_ADDR_WIDTH-1:0]  wb_base_addr_i,
    output logic                       wb_busy_o,
    output logic                       wb_done_o,
    output logic                       arr_rd_en_o,
    output logic [WORD_ADDR_WIDTH-1:0] arr_addr_o,
    input  logic [31:0]                arr_data_i,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [31:0]                mem_data_o,
    output logic [3:0]                 mem_strb_o,
    output logic                       mem_last_o
`ifdef DCACHE_WB_STALL_CNT_EN
    ,
    output logic [31:0]                wb_stall_cnt_o
`endif
);

    localparam int unsigned BYTE_SHIFT = $clog2(WORD_BYTES);
    localparam int unsigned OFS_BITS   = WORD_ADDR_WIDTH + BYTE_SHIFT;
    localparam logic [WORD_ADDR_WIDTH:0]   LINE_WORDS = (WORD_ADDR_WIDTH+1)'(line_words(WORD_ADDR_WIDTH));
    localparam logic [WORD_ADDR_WIDTH-1:0] LAST_IDX   = '1;

    logic [1:0]                 state_r;
    logic [1:0]                 state_next_s;
    logic [MEM_ADDR_WIDTH-1:0]  base_r;
    logic [WORD_ADDR_WIDTH:0]   rd_idx_r;
    logic                       inflight_r;
    logic [WORD_ADDR_WIDTH-1:0] inflight_idx_r;

    logic [WORD_ADDR_WIDTH-1:0] head_idx_s;
    logic [31:0]                head_data_s;
    logic [1:0]                 occ_s;
    logic                       empty_s;
    logic                       valid_s;
    logic                       pop_s;
    logic                       issue_s;
    logic                       last_beat_s;
    logic [1:0]                 outstanding_s;

    assign valid_s     = !empty_s;
    assign pop_s       = valid_s && mem_ready_i;
    assign last_beat_s = (head_idx_s == LAST_IDX);

    // Words already buffered or in flight, after this cycle's pop. Counting
    // the pop lets a new read go out while the head drains, which is what
    // sustains one beat per cycle with only two buffer entries.
    assign outstanding_s = occ_s + {1'b0, inflight_r} - {1'b0, pop_s};
    assign issue_s = (state_r == ST_STREAM) && (rd_idx_r < LINE_WORDS) && (outstanding_s < 2'd2);

    // Next-state decode for the writeback sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wb_req_valid_i) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (pop_s && last_beat_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, captured line base, read index and in-flight read tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= ST_IDLE;
            base_r         <= '0;
            rd_idx_r       <= '0;
            inflight_r     <= 1'b0;
            inflight_idx_r <= '0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_IDLE) && wb_req_valid_i) begin
                base_r   <= {wb_base_addr_i[MEM_ADDR_WIDTH-1:OFS_BITS], {OFS_BITS{1'b0}}};
                rd_idx_r <= '0;
            end else if (issue_s) begin
                rd_idx_r <= rd_idx_r + (WORD_ADDR_WIDTH+1)'(1);
            end
            inflight_r     <= issue_s;
            inflight_idx_r <= rd_idx_r[WORD_ADDR_WIDTH-1:0];
        end
    end

    // Read data lands in the buffer on the edge after its read strobe
    wb_beat_buffer #(
        .IDX_W  (WORD_ADDR_WIDTH),
        .DATA_W (32)
    ) u_beat_buffer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (inflight_r),
        .push_idx  (inflight_idx_r),
        .push_data (arr_data_i),
        .pop       (pop_s),
        .head_idx  (head_idx_s),
        .head_data (head_data_s),
        .occupancy (occ_s),
        .empty     (empty_s)
    );

    assign wb_req_ready_o = (state_r == ST_IDLE);
    assign wb_busy_o      = (state_r != ST_IDLE);
    assign wb_done_o      = (state_r == ST_DONE);
    assign arr_rd_en_o    = issue_s;
    assign arr_addr_o     = issue_s ? rd_idx_r[WORD_ADDR_WIDTH-1:0] : '0;

    // Beat fields come straight from the buffer head, so they hold while stalled
    assign mem_valid_o = valid_s;
    assign mem_addr_o  = valid_s ? (base_r | (MEM_ADDR_WIDTH'(head_idx_s) << BYTE_SHIFT)) : '0;
    assign mem_data_o  = valid_s ? head_data_s : 32'h0000_0000;
    assign mem_strb_o  = valid_s ? STRB_FULL : 4'h0;
    assign mem_last_o  = valid_s && last_beat_s;

`ifdef DCACHE_WB_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of offered-but-refused beat cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (valid_s && !mem_ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign wb_stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_data_cache_line_writeback.sv
// Self-checking bench for data_cache_line_writeback (8-word lines, 32-bit
// addresses). Array contents and the expected beat sequence come from a
// behavioural array model; beats are scored as they are accepted.
module tb_data_cache_line_writeback;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk_i;
    logic        rst_ni;
    logic        wb_req_valid_i;
    logic        wb_req_ready_o;
    logic [31:0] wb_base_addr_i;
    logic        wb_busy_o;
    logic        wb_done_o;
    logic        arr_rd_en_o;
    logic [2:0]  arr_addr_o;
    logic [31:0] arr_data_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_strb_o;
    logic        mem_last_o;
`ifdef DCACHE_WB_STALL_CNT_EN
    logic [31:0] wb_stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] arr_mem [8];
    beat_t       exp_q[$];
    int          beats_acc;
    int          reads_issued;
    bit          rand_ready;
    bit          hold_armed;
    int          hold_at;
    int          hold_len;
    int          hold_left;
    bit          prev_stall;
    logic [31:0] held_addr;
    logic [31:0] held_data;
    logic        held_last;

    data_cache_line_writeback #(
        .WORD_ADDR_WIDTH (3),
        .MEM_ADDR_WIDTH  (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wb_req_valid_i (wb_req_valid_i),
        .wb_req_ready_o (wb_req_ready_o),
        .wb_base_addr_i (wb_base_addr_i),
        .wb_busy_o      (wb_busy_o),
        .wb_done_o      (wb_done_o),
        .arr_rd_en_o    (arr_rd_en_o),
        .arr_addr_o     (arr_addr_o),
        .arr_data_i     (arr_data_i),
        .mem_valid_o    (mem_valid_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_strb_o     (mem_strb_o),
        .mem_last_o     (mem_last_o)
`ifdef DCACHE_WB_STALL_CNT_EN
        ,
        .wb_stall_cnt_o (wb_stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Synchronous-read array model: data for a strobed address appears next cycle
    initial begin
        logic       pend_en;
        logic [2:0] pend_addr;
        arr_data_i = 32'h0;
        forever begin
            @(negedge clk_i);
            pend_en   = arr_rd_en_o;
            pend_addr = arr_addr_o;
            @(posedge clk_i);
            #1;
            if (pend_en) arr_data_i = arr_mem[pend_addr];
        end
    end

    // Memory-side ready: always ready, random, or a scripted hold at one beat
    initial begin
        mem_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (hold_left > 0) begin
                mem_ready_i = 1'b0;
                hold_left--;
            end else if (hold_armed && beats_acc == hold_at) begin
                hold_armed  = 1'b0;
                hold_left   = hold_len - 1;
                mem_ready_i = 1'b0;
            end else if (rand_ready) begin
                mem_ready_i = 1'($urandom_range(0, 1));
            end else begin
                mem_ready_i = 1'b1;
            end
        end
    end

    // Beat scoreboard, hold-stability and outstanding-read monitor
    initial begin
        beat_t e;
        int    outstanding;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (arr_rd_en_o) reads_issued++;
                if (mem_valid_o) begin
                    check("strb", {28'h0, mem_strb_o}, 32'h0000_000F);
                    if (prev_stall) begin
                        check("hold_addr", mem_addr_o, held_addr);
                        check("hold_data", mem_data_o, held_data);
                        check("hold_last", {31'h0, mem_last_o}, {31'h0, held_last});
                    end
                    outstanding = reads_issued - beats_acc - (mem_ready_i ? 1 : 0);
                    check("outstanding_le2", (outstanding > 2) ? 32'd1 : 32'd0, 32'd0);
                    if (mem_ready_i) begin
                        if (exp_q.size() == 0) begin
                            check("extra_beat", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_addr", mem_addr_o, e.addr);
                            check("beat_data", mem_data_o, e.data);
                            check("beat_last", {31'h0, mem_last_o}, {31'h0, e.last});
                        end
                        beats_acc++;
                    end
                    prev_stall = !mem_ready_i;
                    held_addr  = mem_addr_o;
                    held_data  = mem_data_o;
                    held_last  = mem_last_o;
                end else begin
                    if (prev_stall) check("hold_valid", 32'd0, 32'd1);
                    check("strb_idle", {28'h0, mem_strb_o}, 32'h0);
                    prev_stall = 1'b0;
                end
            end
        end
    end

    task automatic prepare_line(input logic [31:0] base);
        beat_t b;
        logic [31:0] line_base;
        line_base = base & 32'hFFFF_FFE0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            b.addr = line_base + 32'(4 * k);
            b.data = arr_mem[k];
            b.last = (k == 7);
            exp_q.push_back(b);
        end
        beats_acc    = 0;
        reads_issued = 0;
        prev_stall   = 1'b0;
    endtask

    task automatic request(input logic [31:0] base);
        int w;
        w = 0;
        while (!wb_req_ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        check("req_ready_idle", {31'h0, wb_req_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        wb_req_valid_i = 1'b1;
        wb_base_addr_i = base;
        @(posedge clk_i);
        #1;
        wb_req_valid_i = 1'b0;
        wb_base_addr_i = $urandom;
    endtask

    task automatic run_line(input logic [31:0] base, input bit rnd, input int h_at,
                            input int h_len, input int exp_lat);
        int  cyc;
        bit  done_seen;
        prepare_line(base);
        rand_ready = rnd;
        hold_at    = h_at;
        hold_len   = h_len;
        hold_armed = (h_len > 0);
        request(base);
        cyc       = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk_i);
            cyc++;
            check("busy_during_line", {31'h0, wb_busy_o}, 32'd1);
            check("ready_low_busy", {31'h0, wb_req_ready_o}, 32'd0);
            if (wb_done_o) begin
                done_seen = 1'b1;
            end else begin
                wb_req_valid_i = 1'($urandom_range(0, 1));
                wb_base_addr_i = $urandom;
            end
        end
        wb_req_valid_i = 1'b0;
        check("done_seen", {31'h0, done_seen}, 32'd1);
        if (exp_lat > 0) check("done_latency", 32'(cyc), 32'(exp_lat));
        check("beat_count", 32'(beats_acc), 32'd8);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk_i);
        check("done_single", {31'h0, wb_done_o}, 32'd0);
        check("ready_after", {31'h0, wb_req_ready_o}, 32'd1);
        check("busy_after", {31'h0, wb_busy_o}, 32'd0);
        rand_ready = 1'b0;
    endtask

    initial begin
        int w;
        rst_ni         = 1'b0;
        wb_req_valid_i = 1'b0;
        wb_base_addr_i = 32'h0;
        rand_ready     = 1'b0;
        hold_armed     = 1'b0;
        hold_left      = 0;
        hold_at        = 0;
        hold_len       = 0;
        beats_acc      = 0;
        reads_issued   = 0;
        prev_stall     = 1'b0;
        for (int k = 0; k < 8; k++) arr_mem[k] = 32'hA5A5_0000 + 32'(k);
        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'h0, wb_req_ready_o}, 32'd1);
        check("rst_busy", {31'h0, wb_busy_o}, 32'd0);
        check("rst_done", {31'h0, wb_done_o}, 32'd0);
        check("rst_rd_en", {31'h0, arr_rd_en_o}, 32'd0);
        check("rst_valid", {31'h0, mem_valid_o}, 32'd0);
        check("rst_strb", {28'h0, mem_strb_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Fixed pattern, memory always ready: 11-cycle request-to-done
        run_line(32'h0000_1040, 1'b0, 0, 0, 11);
        // Unaligned base: low five bits dropped
        run_line(32'h0000_107F, 1'b0, 0, 0, 11);
        // Five-cycle stall on beat 3
        run_line(32'h0000_2000, 1'b0, 3, 5, 16);

        // Random data, random ready, random bases
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 8; k++) arr_mem[k] = $urandom;
            run_line($urandom, 1'b1, 0, 0, 0);
        end

        // Reset in the middle of a line, after beat 4 is accepted
        for (int k = 0; k < 8; k++) arr_mem[k] = 32'h5A5A_0000 + 32'(k);
        prepare_line(32'h0000_3000);
        request(32'h0000_3000);
        w = 0;
        while (beats_acc < 5 && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        check("reached_beat4", 32'(beats_acc), 32'd5);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("abort_ready", {31'h0, wb_req_ready_o}, 32'd1);
        check("abort_busy", {31'h0, wb_busy_o}, 32'd0);
        check("abort_valid", {31'h0, mem_valid_o}, 32'd0);
        check("abort_rd_en", {31'h0, arr_rd_en_o}, 32'd0);
        check("abort_strb", {28'h0, mem_strb_o}, 32'd0);
        check("abort_done", {31'h0, wb_done_o}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("abort_no_done", {31'h0, wb_done_o}, 32'd0);
            check("abort_no_beat", {31'h0, mem_valid_o}, 32'd0);
        end
        exp_q.delete();
        prev_stall = 1'b0;
        rst_ni     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("post_rst_no_done", {31'h0, wb_done_o}, 32'd0);
            check("post_rst_no_beat", {31'h0, mem_valid_o}, 32'd0);
        end

        // Restart from beat 0 after the abort, with a seven-cycle stall
        run_line(32'h0000_3000, 1'b0, 3, 7, 18);
`ifdef DCACHE_WB_STALL_CNT_EN
        check("stall_cnt", wb_stall_cnt_o, 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
